booth_mult_param: RTL and testbench

Parametrised radix-2 Booth multiplier for the CPU's MULT/MULTU path. It supports signed and unsigned operation through a per-operation mode bit, uses a start/busy/done handshake, and has a synchronous cancel. The HI/LO product registers feed the HI/LO architectural registers; the control FSM pulses start and waits for done.

---
 rtl/booth_mult_param_pkg.sv | 16 +
 rtl/booth_mult_param_step.sv | 37 +++
 rtl/booth_mult_param.sv | 115 +++++++++++
 tb/tb_booth_mult_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_param_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encoding and Booth decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // {Q0, q_minus1} patterns that require an add or a subtract of M
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_param_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift right of {acc,Q,q_minus1}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH:0]   q,
    input  logic             q_minus1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH+1:0] acc_next,
    output logic [WIDTH:0]   q_next,
    output logic             q_minus1_next
);

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    // M is already sign/zero extended to WIDTH+1; one more sign bit matches the accumulator
    assign m_ext = {m[WIDTH], m};

    // Booth decode, add/sub, then shift the whole {acc,Q,q_minus1} chain right by one
    always_comb begin
        sum = acc;
        case ({q[0], q_minus1})
            BOOTH_ADD: sum = acc + m_ext;
            BOOTH_SUB: sum = acc - m_ext;
            default:   sum = acc;
        endcase
        acc_next      = {sum[WIDTH+1], sum[WIDTH+1:1]};
        q_next        = {sum[0], q[WIDTH:1]};
        q_minus1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_param.sv
// Radix-2 Booth multiplier for MULT/MULTU; signed and unsigned share one WIDTH+1 bit datapath.
// Latency: done pulses WIDTH+2 edges after the start edge; one operation per WIDTH+2 cycles.
// Backpressure: start is ignored while busy (no queueing); cancel aborts without touching hi/lo.
module booth_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    // Count value seen on the edge that performs the final (WIDTH+1)th step
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

    state_t           state, state_next;
    logic             load, step, finish;
    logic [CNT_W-1:0] count;
    logic [WIDTH+1:0] acc, acc_next;
    logic [WIDTH:0]   q, q_next;
    logic [WIDTH:0]   m;
    logic             q_minus1, q_minus1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc           (acc),
        .q             (q),
        .q_minus1      (q_minus1),
        .m             (m),
        .acc_next      (acc_next),
        .q_next        (q_next),
        .q_minus1_next (q_minus1_next)
    );

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and datapath controls; cancel outranks start and any in-flight work
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST_STEP) state_next = FINISH;
                end
            end
            FINISH: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration registers and the product/result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            q_minus1 <= 1'b0;
            m        <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                m        <= {is_signed & a[WIDTH-1], a};
                q        <= {is_signed & b[WIDTH-1], b};
                acc      <= '0;
                q_minus1 <= 1'b0;
                count    <= '0;
            end else if (step) begin
                acc      <= acc_next;
                q        <= q_next;
                q_minus1 <= q_minus1_next;
                count    <= count + CNT_W'(1);
            end
            // Low 2*WIDTH bits of {acc,Q} hold the product for both signed and unsigned modes
            if (finish) {hi, lo} <= {acc[WIDTH-2:0], q};
        end
    end

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: WIDTH=32 and WIDTH=8 instances share one stimulus stream.
// Each instance has an arithmetic reference model compared every cycle, plus literal checks.
module tb_booth_mult_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy32, done32, busy8, done8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;
    bit armed = 1'b0;
    int done_cnt32 = 0;
    int lat;
    int d0;

    always #5 clk = ~clk;

    booth_mult_param #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed), .cancel(cancel),
        .a(a), .b(b), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    booth_mult_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed), .cancel(cancel),
        .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: plain integer multiply of the w-bit operands, kept modulo 2^(2w)
    function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y,
                                              input bit sgn, input int w);
        logic signed [127:0] sx, sy, p, one;
        logic [127:0] mask;
        one  = 1;
        mask = (128'd1 << w) - 128'd1;
        sx   = signed'({64'd0, x} & mask);
        sy   = signed'({64'd0, y} & mask);
        if (sgn && x[w-1]) sx = sx - (one << w);
        if (sgn && y[w-1]) sy = sy - (one << w);
        p = sx * sy;
        return unsigned'(p) & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    // Model: an accepted request produces its product WIDTH+2 edges later unless cancelled
    int           mw[2] = '{32, 8};
    bit           m_busy[2];
    bit           m_done[2];
    int           m_left[2];
    bit [127:0]   m_prod[2];
    bit [63:0]    m_hi[2];
    bit [63:0]    m_lo[2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0;
                m_hi[k] = '0;  m_lo[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] = 0;
                if (!m_busy[k]) begin
                    if (start && !cancel) begin
                        m_busy[k] = 1;
                        m_left[k] = mw[k] + 2;
                        m_prod[k] = ref_prod({32'd0, a}, {32'd0, b}, is_signed, mw[k]);
                    end
                end else if (cancel) begin
                    m_busy[k] = 0;
                end else begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 0;
                        m_done[k] = 1;
                        m_hi[k]   = 64'((m_prod[k] >> mw[k]) & ((128'd1 << mw[k]) - 128'd1));
                        m_lo[k]   = 64'(m_prod[k] & ((128'd1 << mw[k]) - 128'd1));
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("busy32", {63'd0, busy32}, {63'd0, m_busy[0]});
            chk("done32", {63'd0, done32}, {63'd0, m_done[0]});
            chk("hi32", {32'd0, hi32}, m_hi[0]);
            chk("lo32", {32'd0, lo32}, m_lo[0]);
            chk("busy8", {63'd0, busy8}, {63'd0, m_busy[1]});
            chk("done8", {63'd0, done8}, {63'd0, m_done[1]});
            chk("hi8", {56'd0, hi8}, m_hi[1]);
            chk("lo8", {56'd0, lo8}, m_lo[1]);
        end
        if (done32) done_cnt32++;
    end

    // Single-cycle start pulse; call and return #1 after a rising edge
    task automatic go(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        is_signed = sgn; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done32 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy32}, 64'd0);
        chk("rst_done", {63'd0, done32}, 64'd0);
        chk("rst_hilo", {hi32, lo32}, 64'd0);
        chk("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        cycles(3);
        reset_n = 1'b1;
        armed = 1'b1;
        cycles(2);

        // signed -1 * 5
        go(1'b1, 32'hFFFF_FFFF, 32'd5);
        wait_done(lat);
        chk("lat_signed", 64'(lat), 64'd34);
        chk("signed_basic", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("signed_basic_w8", {48'd0, hi8, lo8}, 64'hFFFB);

        // unsigned 0xFFFFFFFF * 5, issued in the done cycle
        go(1'b0, 32'hFFFF_FFFF, 32'd5);
        wait_done(lat);
        chk("lat_unsigned", 64'(lat), 64'd34);
        chk("unsigned_basic", {hi32, lo32}, 64'h0000_0004_FFFF_FFFB);
        chk("unsigned_basic_w8", {48'd0, hi8, lo8}, 64'h04FB);

        go(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("unsigned_max", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
        chk("unsigned_max_w8", {48'd0, hi8, lo8}, 64'hFE01);

        go(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        chk("signed_minmin", {hi32, lo32}, 64'h4000_0000_0000_0000);

        go(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("signed_minmax", {hi32, lo32}, 64'hC000_0000_8000_0000);

        // second start while busy is dropped
        cycles(3);
        go(1'b0, 32'd3, 32'd7);
        chk("busy_after_start", {63'd0, busy32}, 64'd1);
        cycles(10);
        go(1'b0, 32'd100, 32'd100);
        wait_done(lat);
        chk("lat_ignored_start", 64'(lat), 64'd23);
        chk("ignore_busy_start", {hi32, lo32}, 64'd21);
        chk("busy_in_done", {63'd0, busy32}, 64'd0);
        // start held in the done cycle is accepted
        go(1'b0, 32'd6, 32'd7);
        chk("busy_after_done_start", {63'd0, busy32}, 64'd1);
        wait_done(lat);
        chk("lat_b2b", 64'(lat), 64'd34);
        chk("b2b_result", {hi32, lo32}, 64'd42);

        // cancel mid-run: no done, result registers untouched
        cycles(2);
        d0 = done_cnt32;
        go(1'b0, 32'd3, 32'd7);
        cycles(5);
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
        chk("cancel_busy", {63'd0, busy32}, 64'd0);
        cycles(40);
        chk("cancel_no_done", 64'(done_cnt32 - d0), 64'd0);
        chk("cancel_hold", {hi32, lo32}, 64'd42);
        go(1'b1, 32'd9, 32'd9);
        wait_done(lat);
        chk("after_cancel", {hi32, lo32}, 64'd81);

        // cancel together with start in IDLE drops the start
        cycles(2);
        cancel = 1'b1;
        go(1'b0, 32'd2, 32'd2);
        cancel = 1'b0;
        chk("cancel_start_idle", {63'd0, busy32}, 64'd0);

        // reset mid-run aborts and clears the result
        cycles(2);
        d0 = done_cnt32;
        go(1'b0, 32'd5, 32'd5);
        cycles(20);
        reset_n = 1'b0;
        #1;
        chk("midrst_hilo", {hi32, lo32}, 64'd0);
        chk("midrst_busy", {63'd0, busy32}, 64'd0);
        chk("midrst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycles(40);
        chk("midrst_no_done", 64'(done_cnt32 - d0), 64'd0);

        // signed -5 * 7 after reset
        go(1'b1, 32'hFFFF_FFFB, 32'd7);
        wait_done(lat);
        chk("signed_neg", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFDD);
        chk("signed_neg_w8", {48'd0, hi8, lo8}, 64'hFFDD);
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
